// File: rtl/reduce3n.sv
// reduce3n: in-place reduction of Rq coefficients (q = 4591) to R3 representatives {0,1,2=-1}.
// Streams one coefficient per cycle: read, register with index, reduce, write back two cycles later.
module reduce3n #(
  parameter int Q  = 4591,
  parameter int AW = 11,
  parameter int DW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] degp,
  input  logic [DW-1:0] mem_output,
  output logic [AW-1:0] mem_address_o,
  output logic [AW-1:0] mem_address_i,
  output logic [DW-1:0] mem_input,
  output logic          write_enable,
  output logic          busy,
  output logic          done
);

  localparam int HALFQ = (Q - 1) / 2;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t        state;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] last;
  logic [AW-1:0] idx1;
  logic          v1;
  logic          drain_cnt;
  logic [DW:0]   t;
  logic [1:0]    r;

  // Values above HALFQ are negative once centred; v - Q == v + 2 (mod 3) because Q == 1 (mod 3).
  always_comb begin
    t = {1'b0, mem_output};
    if (mem_output > DW'(HALFQ)) t = {1'b0, mem_output} + (DW+1)'(2);
    r = 2'(t % (DW+1)'(3));
  end

  assign mem_address_o = rd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rd_addr       <= '0;
      last          <= '0;
      idx1          <= '0;
      v1            <= 1'b0;
      drain_cnt     <= 1'b0;
      mem_address_i <= '0;
      mem_input     <= '0;
      write_enable  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      // Stage 1 carries the index of the read whose data returns next cycle.
      v1   <= (state == READ);
      idx1 <= rd_addr;

      write_enable  <= v1;
      mem_address_i <= v1 ? idx1 : '0;
      mem_input     <= v1 ? {{(DW-2){1'b0}}, r} : '0;

      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            last    <= degp;
            rd_addr <= '0;
            busy    <= 1'b1;
            state   <= READ;
          end else begin
            state <= IDLE;
          end
        end
        READ: begin
          if (rd_addr == last) begin
            rd_addr   <= '0;
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end else begin
            rd_addr <= rd_addr + AW'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reduce3n.sv
// Bench for reduce3n: synchronous-read memory model, centred mod-3 reference, cycle-exact handshake checks.
module tb_reduce3n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] degp;
  logic [12:0] mem_output;
  logic [10:0] mem_address_o;
  logic [10:0] mem_address_i;
  logic [12:0] mem_input;
  logic        write_enable;
  logic        busy;
  logic        done;

  logic [12:0] mem [0:2047];
  int errors = 0;
  int checks = 0;

  reduce3n dut (
    .clk(clk), .rst_n(rst_n), .start(start), .degp(degp),
    .mem_output(mem_output), .mem_address_o(mem_address_o),
    .mem_address_i(mem_address_i), .mem_input(mem_input),
    .write_enable(write_enable), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_output <= mem[mem_address_o];
    if (write_enable) mem[mem_address_i] <= mem_input;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Centre into (-(q-1)/2 .. (q-1)/2), take the mathematical residue mod 3.
  function automatic logic [12:0] ref_r3(input int v);
    int c;
    c = (v > 2295) ? v - 4591 : v;
    c = c % 3;
    if (c < 0) c += 3;
    return 13'(c);
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_we"}, write_enable, 0);
    chk({tag, "_addr_o"}, mem_address_o, 0);
    chk({tag, "_addr_i"}, mem_address_i, 0);
    chk({tag, "_wdata"}, mem_input, 0);
  endtask

  // Called at a negedge; the following posedge is cycle 0 of the pass.
  task automatic run_pass(input int dp, input bit keep);
    logic [12:0] exp_q [$];
    for (int k = 0; k <= dp; k++) exp_q.push_back(ref_r3(int'(mem[k])));
    start = 1'b1;
    degp  = 11'(dp);
    @(posedge clk);
    #1;
    if (!keep) start = 1'b0;
    for (int n = 1; n <= dp + 4; n++) begin
      @(negedge clk);
      chk("busy", busy, 32'(n <= dp + 3));
      chk("done", done, 32'(n == dp + 4));
      if (n <= dp + 1) chk("rd_addr", mem_address_o, 32'(n - 1));
      chk("we", write_enable, 32'(n >= 3 && n <= dp + 3));
      if (n >= 3 && n <= dp + 3) begin
        chk("wr_addr", mem_address_i, 32'(n - 3));
        chk("wr_data", mem_input, 32'(exp_q[n-3]));
      end else begin
        chk("wr_addr_idle", mem_address_i, 0);
        chk("wr_data_idle", mem_input, 0);
      end
    end
    for (int k = 0; k <= dp; k++) chk("mem_after", mem[k], 32'(exp_q[k]));
  endtask

  initial begin
    logic [12:0] bvals [6];
    logic [12:0] bexp  [6];
    bvals = '{13'd0, 13'd1, 13'd2, 13'd2295, 13'd2296, 13'd4590};
    bexp  = '{13'd0, 13'd1, 13'd2, 13'd0, 13'd0, 13'd2};

    rst_n = 1'b0;
    start = 1'b0;
    degp  = '0;
    for (int k = 0; k < 2048; k++) mem[k] = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 6; k++) mem[k] = bvals[k];
    run_pass(5, 1'b0);
    for (int k = 0; k < 6; k++) chk("boundary", mem[k], 32'(bexp[k]));

    @(negedge clk);
    mem[0] = 13'd3000;
    run_pass(0, 1'b0);
    chk("minimal", mem[0], 2);

    @(negedge clk);
    mem[0] = 13'd8191;
    run_pass(0, 1'b0);
    chk("out_of_range", mem[0], 0);

    @(negedge clk);
    for (int k = 0; k <= 756; k++) mem[k] = 13'($urandom_range(0, 4590));
    mem[757] = 13'd4000;
    run_pass(756, 1'b0);
    chk("no_write_past_end", mem[757], 4000);

    @(negedge clk);
    for (int k = 0; k <= 10; k++) mem[k] = 13'($urandom_range(0, 4590));
    run_pass(10, 1'b1);
    run_pass(10, 1'b0);
    @(negedge clk);
    chk("after_hold_busy", busy, 0);

    @(negedge clk);
    for (int k = 0; k <= 756; k++) mem[k] = 13'($urandom_range(0, 4590));
    start = 1'b1;
    degp  = 11'd756;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 756; k++) mem[k] = 13'($urandom_range(0, 4590));
    run_pass(756, 1'b0);

    for (int p = 0; p < 3; p++) begin
      int dp;
      dp = $urandom_range(1, 40);
      @(negedge clk);
      for (int k = 0; k <= dp; k++) mem[k] = 13'($urandom_range(0, 8191));
      run_pass(dp, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
